// File: rtl/dmi_pass_initiator_if.sv
// Signal bundle between the DMI password initiator and its TAP/checker environment.
// master: the initiator itself; slave: the TAP data path and password checker.
interface dmi_pass_initiator_if;
    logic        tdi_i;
    logic        shift_en_i;
    logic        update_i;
    logic        lock_i;
    logic        pass_chk_i;
    logic [31:0] data_d_o;
    logic        unlocked_o;
    logic        busy_o;
    logic        fail_o;
    logic        locked_out_o;
    logic [1:0]  attempts_o;

    modport master (
        input  tdi_i, shift_en_i, update_i, lock_i, pass_chk_i,
        output data_d_o, unlocked_o, busy_o, fail_o, locked_out_o, attempts_o
    );

    modport slave (
        output tdi_i, shift_en_i, update_i, lock_i, pass_chk_i,
        input  data_d_o, unlocked_o, busy_o, fail_o, locked_out_o, attempts_o
    );
endinterface

// File: rtl/dmi_pass_initiator.sv
// DMI JTAG password unlock initiator: serial candidate capture, timed check, unlock/lockout FSM.
// Define DMI_PASS_LOCKOUT_EN to build attempt counting and the LOCKOUT state.
module dmi_pass_initiator #(
    parameter int CHK_LAT        = 2,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dmi_pass_initiator_if.master  bus
);

    localparam int CW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, UNLOCKED, LOCKOUT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   sr_q, sr_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          failed;
    logic [31:0]   data_q;
    logic          unlocked_q;
    logic          busy_q;
    logic          fail_q;

`ifdef DMI_PASS_LOCKOUT_EN
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic [AW-1:0] att_q, att_d, att_inc;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          locked_q;
    logic [1:0]    attempts_q;

    function automatic logic [1:0] sat_attempts(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return (w > 32'd3) ? 2'd3 : w[1:0];
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        failed  = 1'b0;
`ifdef DMI_PASS_LOCKOUT_EN
        att_d   = att_q;
        lcnt_d  = lcnt_q;
        att_inc = att_q + AW'(1);
`endif
        case (state_q)
            IDLE: begin
                if (bus.lock_i) begin
                    sr_d  = '0;
                    cnt_d = '0;
                end else begin
                    // Shift first so a same-cycle update sees the post-shift count
                    if (bus.shift_en_i) begin
                        sr_d = {bus.tdi_i, sr_q[31:1]};
                        if (cnt_q != 6'd32)
                            cnt_d = cnt_q + 6'd1;
                    end
                    if (bus.update_i) begin
                        if (cnt_d == 6'd32) begin
                            state_d = CHECK;
                            hold_d  = CW'(CHK_LAT - 1);
                        end else begin
                            failed = 1'b1;
                        end
                    end
                end
            end
            CHECK: begin
                if (bus.lock_i) begin
                    state_d = IDLE;
                    sr_d    = '0;
                    cnt_d   = '0;
                end else if (hold_q == '0) begin
                    if (bus.pass_chk_i) begin
                        state_d = UNLOCKED;
                        sr_d    = '0;
                        cnt_d   = '0;
`ifdef DMI_PASS_LOCKOUT_EN
                        att_d   = '0;
`endif
                    end else begin
                        failed = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - CW'(1);
                end
            end
            UNLOCKED: begin
                if (bus.lock_i)
                    state_d = IDLE;
            end
`ifdef DMI_PASS_LOCKOUT_EN
            LOCKOUT: begin
                if (lcnt_q == '0) begin
                    state_d = IDLE;
                    att_d   = '0;
                end else begin
                    lcnt_d = lcnt_q - LW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (failed) begin
            sr_d  = '0;
            cnt_d = '0;
`ifdef DMI_PASS_LOCKOUT_EN
            att_d = att_inc;
            if (att_inc >= AW'(MAX_ATTEMPTS)) begin
                state_d = LOCKOUT;
                lcnt_d  = LW'(LOCKOUT_CYCLES - 1);
            end else begin
                state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Outputs are decoded from the next state so they change together with it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            data_q     <= '0;
            unlocked_q <= 1'b0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            data_q     <= (state_d == CHECK) ? sr_d : '0;
            unlocked_q <= (state_d == UNLOCKED);
            busy_q     <= (state_d == CHECK) || (state_d == LOCKOUT);
            fail_q     <= failed;
        end
    end

`ifdef DMI_PASS_LOCKOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            att_q      <= '0;
            lcnt_q     <= '0;
            locked_q   <= 1'b0;
            attempts_q <= '0;
        end else begin
            att_q      <= att_d;
            lcnt_q     <= lcnt_d;
            locked_q   <= (state_d == LOCKOUT);
            attempts_q <= sat_attempts(att_d);
        end
    end

    assign bus.locked_out_o = locked_q;
    assign bus.attempts_o   = attempts_q;
`else
    assign bus.locked_out_o = 1'b0;
    assign bus.attempts_o   = 2'd0;
`endif

    assign bus.data_d_o   = data_q;
    assign bus.unlocked_o = unlocked_q;
    assign bus.busy_o     = busy_q;
    assign bus.fail_o     = fail_q;

endmodule

// File: doc/dmi_pass_initiator.md
# dmi_pass_initiator

Debug-side initiator for the DMI JTAG password unlock. It shifts a 32-bit candidate password in serially from the TAP data path and presents it to the password checker as a parallel word. It samples the checker's match flag, tracks failed attempts and drives the debug-unlock state consumed by the DMI front end. It sits between the TAP shift/update strobes and the combinational password comparator.

## Interface
- CHK_LAT, default 2: cycles `data_d_o` is held before `pass_chk_i` is sampled (≥1).
- MAX_ATTEMPTS, default 3: consecutive failures before lockout (≥1).
- LOCKOUT_CYCLES, default 1024: lockout duration in cycles (≥1).
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- tdi_i  in  1  serial password bit.
- shift_en_i  in  1  shift `tdi_i` into the candidate register this cycle.
- update_i  in  1  single-cycle strobe requesting a check.
- lock_i  in  1  relock request from the debug module.
- pass_chk_i  in  1  match flag from the checker.
- data_d_o  out  32  candidate word to the checker.
- unlocked_o  out  1  debug access granted.
- busy_o  out  1  check or lockout in progress.
- fail_o  out  1  one-cycle pulse per failed attempt.
- locked_out_o  out  1  lockout active.
- attempts_o  out  2  consecutive failure count, saturating.

## Operation
- States: IDLE, CHECK, UNLOCKED, LOCKOUT.
- Shift register `sr` (32b) and bit counter `cnt` (6b, saturates at 32):
  - Shifting happens only in IDLE, LSB first: `sr <= {tdi_i, sr[31:1]}` and `cnt` increments on each `shift_en_i`.
  - `shift_en_i` in any other state is ignored.
- IDLE + `update_i`:
  - If `cnt == 32`: go to CHECK and load a hold counter with CHK_LAT-1.
  - If `cnt != 32`: counts as a failed attempt with no check. Pulse `fail_o`, clear `sr` and `cnt`, and stay in IDLE (or go to LOCKOUT).
- `shift_en_i` and `update_i` in the same cycle: the shift is applied first, and `update_i` is evaluated against the post-shift `cnt`.
- CHECK:
  - `data_d_o = sr`.
  - On the cycle the hold counter reaches 0, sample `pass_chk_i`.
  - Pass (1): go to UNLOCKED and clear `attempts_o`.
  - Fail (0): pulse `fail_o` and increment `attempts_o`. If the count reaches MAX_ATTEMPTS, go to LOCKOUT; otherwise go to IDLE.
  - Either way, clear `sr` and `cnt`.
- `data_d_o` is 32'h0 in every state except CHECK. No password residue is left on the bus.
- UNLOCKED: `unlocked_o=1` until `lock_i`, then return to IDLE the next cycle. `update_i` is ignored.
- LOCKOUT: `locked_out_o=1` and `busy_o=1`. A down-counter loaded with LOCKOUT_CYCLES-1 runs; when it reaches 0, go to IDLE and clear `attempts_o`. `update_i` and `lock_i` are ignored.
- `lock_i` in IDLE or CHECK: abort. Return to (or stay in) IDLE, clear `sr` and `cnt`, do not pulse `fail_o`, and leave `attempts_o` unchanged.
- `busy_o` = state is CHECK or LOCKOUT.

## Timing
- Reset values: `sr=0`, `cnt=0`, state=IDLE, `data_d_o=0`, `unlocked_o=0`, `busy_o=0`, `fail_o=0`, `locked_out_o=0`, `attempts_o=0`.
- Reset mid-CHECK or mid-LOCKOUT returns to IDLE with the reset values on the next edge.
- All outputs are registered.
- `update_i` at cycle T puts CHECK on cycle T+1, and `data_d_o` is valid from T+1.
- `pass_chk_i` is sampled at T+CHK_LAT, and the resulting state (UNLOCKED/IDLE/LOCKOUT) appears at T+CHK_LAT+1.
- `fail_o` is asserted in exactly the cycle the failing state is entered.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.

## Configuration
- `DMI_PASS_LOCKOUT_EN` defined: attempt counting and LOCKOUT behave as above.
- Undefined:
  - LOCKOUT state, its counter and the attempt counter are not built.
  - `locked_out_o` is tied to 0 and `attempts_o` to 0.
  - A failure always returns to IDLE, so retries are unlimited.

## Test plan
- Shift 32'hDEADBEEF LSB first, then `update_i`, with the checker matching 32'hDEADBEEF: `unlocked_o=1` at update+3, and `data_d_o` returns to 0 at the same time.
- Shift 32'h12345678 against the checker's 32'hDEADBEEF: `fail_o` pulses one cycle, `attempts_o=1`, back in IDLE, `sr=0`.
- Three wrong words with the macro defined: `locked_out_o` high for exactly 1024 cycles, then IDLE and `attempts_o=0`. A correct word sent during the lockout does not unlock.
- Only 20 bits shifted, then `update_i`: `fail_o` pulses, and `data_d_o` never becomes nonzero.
- `lock_i` while UNLOCKED: `unlocked_o` is 0 the next cycle. `lock_i` during CHECK: abort with no `fail_o` and `attempts_o` unchanged.
- `rst_i` at cycle 500 of LOCKOUT: all outputs take their reset values next cycle. Without the macro, 5 wrong words give 5 `fail_o` pulses and no lockout.
